// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state type, default line constants
// and the clocks-per-bit helper used by the transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115_200;

    // Clocks per bit, truncated; callers must keep the result >= 2.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and pulses tick on the last count.
// Ports: clk, rst_n (async low), clr (restart at 0), tick (one clock).
module uart_baud_gen #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter, valid/ready byte input, gated by a startup enable.
// Ports: sys_clk, sys_rst_n, en, tx_data/tx_valid/tx_ready, uart_txd, tx_busy.
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       tx_busy
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);

    tx_state_t  state;
    logic       armed;
    logic       txd;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       tick;
    logic       accept;

    // Ready is decoded purely from registers; no input reaches it.
    assign tx_ready = armed && (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign uart_txd = txd;

    // Clearing on accept aligns the first bit period to the start edge.
    uart_baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (accept),
        .tick  (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            armed   <= 1'b0;
            txd     <= 1'b1;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            // Sticky: once the startup stage enables us we stay enabled.
            if (en) begin
                armed <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (accept) begin
                        state   <= START;
                        txd     <= 1'b0;
                        shreg   <= tx_data;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            txd     <= 1'b1;
                            bit_idx <= '0;
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Self-checking bench for uart_tx_8n1 at CLK_FREQ=1000, BAUD=100 (10 clk/bit).
// Frame-level reference model plus directed and random frames.
module tb_uart_tx_8n1;

    localparam int BDIV  = 10;
    localparam int FRAME = 10 * BDIV;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_txd;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    uart_tx_8n1 #(
        .CLK_FREQ (1000),
        .BAUD     (100)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Reference model: a frame is "accepted" when valid meets an armed,
    // idle transmitter; it then owns the line for FRAME clocks, and the
    // line level is the frame bit indexed by elapsed clocks / BDIV.
    bit         m_armed = 1'b0;
    int         m_left  = 0;
    logic [9:0] m_frame = '1;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_armed <= 1'b0;
            m_left  <= 0;
        end else begin
            if (m_left > 0) begin
                m_left <= m_left - 1;
            end else if (tx_valid && m_armed) begin
                m_left  <= FRAME;
                m_frame <= {1'b1, tx_data, 1'b0};
            end
            if (en) begin
                m_armed <= 1'b1;
            end
        end
    end

    always @(negedge sys_clk) begin
        logic [2:0] exp;
        logic       e_txd;
        if (!done) begin
            e_txd = (m_left == 0) ? 1'b1 :
                    m_frame[(FRAME - m_left) / BDIV];
            exp = {e_txd, m_armed && (m_left == 0), m_left > 0};
            check("model_txd_ready_busy",
                  {29'd0, uart_txd, tx_ready, tx_busy}, {29'd0, exp});
        end
    end

    task automatic send(input logic [7:0] d, input bit keep,
                        output logic [9:0] got, output time t0);
        int n;
        n = 0;
        got = '1;
        t0 = 0;
        tx_data = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        check("ready_wait", {31'd0, tx_ready}, 32'd1);
        if (tx_ready !== 1'b1) begin
            tx_valid = 1'b0;
            return;
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        t0 = $time;
        if (!keep) tx_valid = 1'b0;
        repeat (BDIV / 2) @(negedge sys_clk);
        got[0] = uart_txd;
        for (int k = 1; k < 10; k++) begin
            repeat (BDIV) @(negedge sys_clk);
            got[k] = uart_txd;
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        en = 1'b0;
        tx_valid = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] got;
        time        t1;
        time        t2;
        int         n;
        logic [7:0] d;

        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0};
        vecs[4] = '{8'h55, 10'b1_01010101_0};

        // Reset, then 50 clocks with en low and valid held high.
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (50) @(negedge sys_clk);
        check("idle_txd", {31'd0, uart_txd}, 32'd1);
        check("idle_ready", {31'd0, tx_ready}, 32'd0);
        check("idle_busy", {31'd0, tx_busy}, 32'd0);

        // en rises: ready one clock later, no accept on that edge.
        en = 1'b1;
        @(negedge sys_clk);
        check("ready_after_en", {31'd0, tx_ready}, 32'd1);
        check("no_accept_at_en", {31'd0, tx_busy}, 32'd0);
        send(vecs[0].data, 1'b0, got, t1);
        check("frame_a5", {22'd0, got}, {22'd0, vecs[0].frame});
        repeat (4) @(negedge sys_clk);
        check("busy_clk99", {31'd0, tx_busy}, 32'd1);
        @(negedge sys_clk);
        check("busy_clk100", {31'd0, tx_busy}, 32'd0);
        check("ready_clk100", {31'd0, tx_ready}, 32'd1);

        // Back-to-back with valid held: 101 clocks start to start.
        send(vecs[1].data, 1'b1, got, t1);
        check("frame_00", {22'd0, got}, {22'd0, vecs[1].frame});
        send(vecs[2].data, 1'b0, got, t2);
        check("frame_ff", {22'd0, got}, {22'd0, vecs[2].frame});
        check("b2b_spacing", 32'((t2 - t1) / 10), 32'd101);

        // Whole table, one frame each.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data, 1'b0, got, t1);
            check("table_frame", {22'd0, got}, {22'd0, vecs[i].frame});
        end

        // en pulses for one clock only: armed must stick.
        do_reset();
        en = 1'b1;
        @(negedge sys_clk);
        en = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("armed_sticky", {31'd0, tx_ready}, 32'd1);
        send(vecs[3].data, 1'b0, got, t1);
        check("frame_3c", {22'd0, got}, {22'd0, vecs[3].frame});

        // Reset during data bit 4 of 8'h55.
        tx_data = vecs[4].data;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        tx_valid = 1'b0;
        repeat (45) @(negedge sys_clk);
        check("bit3_55", {31'd0, uart_txd}, {31'd0, vecs[4].frame[4]});
        repeat (10) @(negedge sys_clk);
        check("bit4_busy", {31'd0, tx_busy}, 32'd1);
        #2;
        sys_rst_n = 1'b0;
        en = 1'b0;
        #1;
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_ready", {31'd0, tx_ready}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tx_valid = 1'b1;
        repeat (30) @(negedge sys_clk);
        check("post_rst_txd", {31'd0, uart_txd}, 32'd1);
        check("post_rst_ready", {31'd0, tx_ready}, 32'd0);
        check("post_rst_busy", {31'd0, tx_busy}, 32'd0);

        // Random bytes, random gaps, random valid holding.
        do_reset();
        en = 1'b1;
        @(negedge sys_clk);
        for (int f = 0; f < 200; f++) begin
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 12)) @(negedge sys_clk);
            d = 8'($urandom);
            send(d, 1'($urandom_range(0, 1)), got, t1);
            check("rand_frame", {22'd0, got}, {22'd0, 1'b1, d, 1'b0});
        end
        tx_valid = 1'b0;
        repeat (FRAME) @(negedge sys_clk);

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
